// File: rtl/key_led_sequencer_if.sv
// Front-panel pin bundle between the raw keys, the LED drivers and the sequencer.
// The slave side is the sequencer; the master side drives the keys and observes the LEDs.
interface key_led_sequencer_if #(
  parameter int NUM_LED = 4
) ();
  logic [1:0]         key;
  logic [NUM_LED-1:0] usr_led;
  logic [1:0]         led_mode;
  logic               mode_change;

  modport master (
    output key,
    input  usr_led,
    input  led_mode,
    input  mode_change
  );

  modport slave (
    input  key,
    output usr_led,
    output led_mode,
    output mode_change
  );
endinterface

// File: rtl/key_led_sequencer.sv
// Front-panel controller: synchronises and debounces two keys into one-cycle
// press events, and steps a four-mode LED pattern at a programmable tick rate.
//
// state       | meaning
// ------------+------------------------------------------------
// MODE_BLINK  | all LEDs toggle together on every tick
// MODE_LEFT   | single lit LED rotates toward the MSB, wrapping
// MODE_RIGHT  | single lit LED rotates toward bit 0, wrapping
// MODE_COUNT  | LEDs show a free-running binary up-counter
module key_led_sequencer #(
  parameter int DEBOUNCE_W = 14,
  parameter int TICK_DIV   = 12_500_000,
  parameter int NUM_LED    = 4
) (
  input logic                clk_50m,
  input logic                rst,
  key_led_sequencer_if.slave bus
);
  localparam int PRESC_W = $clog2(TICK_DIV);

  localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;
  localparam logic [DEBOUNCE_W-1:0] CNT_PRE = {{(DEBOUNCE_W-1){1'b1}}, 1'b0};
  localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

  localparam logic [NUM_LED-1:0] LED_LSB = {{(NUM_LED-1){1'b0}}, 1'b1};
  localparam logic [NUM_LED-1:0] LED_MSB = {1'b1, {(NUM_LED-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  logic [1:0]            key_m;
  logic [1:0]            key_s;
  logic [DEBOUNCE_W-1:0] cnt [2];
  logic [1:0]            press;

  mode_t                 mode;
  mode_t                 mode_next;
  logic [NUM_LED-1:0]    usr_led;
  logic                  mode_change;
  logic [PRESC_W-1:0]    presc;
  logic                  tick;

  function automatic logic [NUM_LED-1:0] seed_of(input mode_t m);
    case (m)
      MODE_LEFT:  seed_of = LED_LSB;
      MODE_RIGHT: seed_of = LED_MSB;
      default:    seed_of = '0;
    endcase
  endfunction

  function automatic logic [NUM_LED-1:0] step_of(input mode_t m,
                                                 input logic [NUM_LED-1:0] led);
    case (m)
      MODE_BLINK: step_of = ~led;
      MODE_LEFT:  step_of = {led[NUM_LED-2:0], led[NUM_LED-1]};
      MODE_RIGHT: step_of = {led[0], led[NUM_LED-1:1]};
      default:    step_of = led + LED_LSB;
    endcase
  endfunction

  // Two-flop synchroniser; nothing else touches the raw pins.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      key_m <= '0;
      key_s <= '0;
    end else begin
      key_m <= bus.key;
      key_s <= key_m;
    end
  end

  // Saturating stable-high counter per key; the press fires only on the
  // M-1 -> M transition, so a held key yields exactly one event.
  for (genvar i = 0; i < 2; i++) begin : g_debounce
    always_ff @(posedge clk_50m) begin
      if (rst) begin
        cnt[i]   <= '0;
        press[i] <= 1'b0;
      end else if (!key_s[i]) begin
        cnt[i]   <= '0;
        press[i] <= 1'b0;
      end else if (cnt[i] == CNT_PRE) begin
        cnt[i]   <= CNT_MAX;
        press[i] <= 1'b1;
      end else if (cnt[i] != CNT_MAX) begin
        cnt[i]   <= cnt[i] + CNT_ONE;
        press[i] <= 1'b0;
      end else begin
        press[i] <= 1'b0;
      end
    end
  end

  // Key 0 steps forward and takes priority when both fire together.
  assign mode_next = press[0] ? mode_t'(mode + 2'd1) : mode_t'(mode - 2'd1);
  assign tick      = (presc == PRESC_LAST);

  // A mode update reloads the seed and restarts the prescaler, which also
  // swallows any tick landing on the same edge.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      mode        <= MODE_BLINK;
      usr_led     <= '0;
      mode_change <= 1'b0;
      presc       <= '0;
    end else begin
      mode_change <= 1'b0;
      if (press[0] || press[1]) begin
        mode        <= mode_next;
        usr_led     <= seed_of(mode_next);
        mode_change <= 1'b1;
        presc       <= '0;
      end else if (tick) begin
        usr_led <= step_of(mode, usr_led);
        presc   <= '0;
      end else begin
        presc <= presc + PRESC_ONE;
      end
    end
  end

  assign bus.usr_led     = usr_led;
  assign bus.led_mode    = mode;
  assign bus.mode_change = mode_change;

endmodule
